// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared elevator encodings, floor bounds and motion FSM states
package elevator_pkg;

    localparam logic ON    = 1'b1;
    localparam logic OFF   = 1'b0;
    localparam logic MOVE  = 1'b1;
    localparam logic HOLD  = 1'b0;
    localparam logic OPEN  = 1'b1;
    localparam logic CLOSE = 1'b0;

    localparam logic [1:0] STOP   = 2'b00;
    localparam logic [1:0] UP     = 2'b10;
    localparam logic [1:0] DOWN   = 2'b01;
    localparam logic [1:0] UPDOWN = 2'b11;

    localparam int FLOOR_MIN = 1;
    localparam int FLOOR_MAX = 7;
    localparam int FLOOR_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        ARRIVE,
        DOOR_OPEN
    } motion_state_t;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - loadable saturating down-counter with tick enable and zero flag
module tick_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadValue,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/car_motion_controller.sv
// rtl/car_motion_controller.sv - moves the car floor by floor and runs the door cycle
// Optional DOOR_REOPEN_EN adds doorObstruct, which holds the door open while asserted.
module car_motion_controller
    import elevator_pkg::*;
#(
    parameter int FLOOR_TICKS  = 8,
    parameter int DOOR_TICKS   = 6,
    parameter int BOTTOM_FLOOR = FLOOR_MIN,
    parameter int TOP_FLOOR    = FLOOR_MAX
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
`ifdef DOOR_REOPEN_EN
    input  logic                          doorObstruct,
`endif
    input  logic [1:0]                    nextDirection,
    input  logic [2*TOP_FLOOR-1:0]        floorButton,
    input  logic [TOP_FLOOR:BOTTOM_FLOOR] internalButton,
    output logic [FLOOR_W-1:0]            currentFloor,
    output logic [1:0]                    currentDirection,
    output logic                          move,
    output logic                          doorState,
    output logic                          arrived
);

    localparam int CW = $clog2(maxOf(FLOOR_TICKS, DOOR_TICKS) + 1);
    localparam logic [FLOOR_W-1:0] TOP_F = FLOOR_W'(TOP_FLOOR);
    localparam logic [FLOOR_W-1:0] BOT_F = FLOOR_W'(BOTTOM_FLOOR);

    motion_state_t state;

    logic          obstruct;
    logic          callHere, internalHere, hallUpHere, hallDownHere;
    logic          anyAbove, anyBelow;
    logic          startMove, stopHere;
    logic          travelLoad, travelDec, travelLast, travelZero;
    logic          doorLoad, doorDec, doorLast, doorZero;
    logic [CW-1:0] travelCount, doorCount;

`ifdef DOOR_REOPEN_EN
    assign obstruct = doorObstruct;
`else
    assign obstruct = 1'b0;
`endif

    always_comb begin
        internalHere = 1'b0;
        hallUpHere   = 1'b0;
        hallDownHere = 1'b0;
        anyAbove     = 1'b0;
        anyBelow     = 1'b0;
        for (int g = BOTTOM_FLOOR; g <= TOP_FLOOR; g++) begin
            if (FLOOR_W'(g) == currentFloor) begin
                internalHere = internalButton[g];
                hallUpHere   = floorButton[2*g-1];
                hallDownHere = floorButton[2*g-2];
            end
            if (FLOOR_W'(g) > currentFloor)
                anyAbove = anyAbove | internalButton[g] | floorButton[2*g-1] | floorButton[2*g-2];
            if (FLOOR_W'(g) < currentFloor)
                anyBelow = anyBelow | internalButton[g] | floorButton[2*g-1] | floorButton[2*g-2];
        end
    end

    assign callHere  = internalHere | hallUpHere | hallDownHere;
    assign startMove = (nextDirection == UP   && currentFloor < TOP_F) ||
                       (nextDirection == DOWN && currentFloor > BOT_F);

    // Bounds force a stop so the car can never be sent past the shaft ends.
    assign stopHere = internalHere ||
                      (currentDirection == UP   && hallUpHere) ||
                      (currentDirection == DOWN && hallDownHere) ||
                      currentFloor == TOP_F || currentFloor == BOT_F ||
                      (currentDirection == UP   && !anyAbove) ||
                      (currentDirection == DOWN && !anyBelow) ||
                      (currentDirection != UP && currentDirection != DOWN);

    assign travelLoad = enable && ((state == IDLE && !callHere && startMove) ||
                                   (state == ARRIVE && !stopHere));
    assign travelDec  = enable && state == MOVING;
    assign doorLoad   = enable && ((state == IDLE && callHere) ||
                                   (state == ARRIVE && stopHere) ||
                                   (state == DOOR_OPEN && obstruct));
    assign doorDec    = enable && state == DOOR_OPEN;

    // A count of one means this tick is the one that reaches zero.
    assign travelLast = travelZero || travelCount == CW'(1);
    assign doorLast   = doorZero || doorCount == CW'(1);

    tick_counter #(.W(CW)) travelTimer (
        .clk       (clk),
        .reset     (reset),
        .load      (travelLoad),
        .loadValue (CW'(FLOOR_TICKS)),
        .dec       (travelDec),
        .count     (travelCount),
        .zero      (travelZero)
    );

    tick_counter #(.W(CW)) doorTimer (
        .clk       (clk),
        .reset     (reset),
        .load      (doorLoad),
        .loadValue (CW'(DOOR_TICKS)),
        .dec       (doorDec),
        .count     (doorCount),
        .zero      (doorZero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            currentFloor     <= BOT_F;
            currentDirection <= STOP;
            move             <= HOLD;
            doorState        <= CLOSE;
            arrived          <= 1'b0;
        end else begin
            arrived <= 1'b0;
            if (enable) begin
                case (state)
                    IDLE: begin
                        currentDirection <= (nextDirection == UPDOWN) ? STOP : nextDirection;
                        if (callHere) begin
                            state     <= DOOR_OPEN;
                            doorState <= OPEN;
                            arrived   <= 1'b1;
                        end else if (startMove) begin
                            state <= MOVING;
                            move  <= MOVE;
                        end
                    end
                    MOVING: begin
                        if (travelLast) begin
                            if (currentDirection == UP && currentFloor < TOP_F)
                                currentFloor <= currentFloor + FLOOR_W'(1);
                            else if (currentDirection == DOWN && currentFloor > BOT_F)
                                currentFloor <= currentFloor - FLOOR_W'(1);
                            state <= ARRIVE;
                        end
                    end
                    ARRIVE: begin
                        if (stopHere) begin
                            state     <= DOOR_OPEN;
                            move      <= HOLD;
                            doorState <= OPEN;
                            arrived   <= 1'b1;
                        end else begin
                            state <= MOVING;
                        end
                    end
                    DOOR_OPEN: begin
                        if (doorLast && !obstruct) begin
                            doorState <= CLOSE;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_car_motion_controller.sv
// tb/tb_car_motion_controller.sv - directed self-checking bench for car_motion_controller
module tb_car_motion_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  nextDirection;
    logic [13:0] floorButton;
    logic [7:1]  internalButton;
    logic [2:0]  currentFloor;
    logic [1:0]  currentDirection;
    logic        move;
    logic        doorState;
    logic        arrived;
`ifdef DOOR_REOPEN_EN
    logic        doorObstruct;
`endif

    int total = 0;
    int bad   = 0;
    int took;

    always #5 clk = ~clk;

    car_motion_controller dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
`ifdef DOOR_REOPEN_EN
        .doorObstruct     (doorObstruct),
`endif
        .nextDirection    (nextDirection),
        .floorButton      (floorButton),
        .internalButton   (internalButton),
        .currentFloor     (currentFloor),
        .currentDirection (currentDirection),
        .move             (move),
        .doorState        (doorState),
        .arrived          (arrived)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitArrived(input int limit, output int n);
        n = 0;
        while (arrived !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("arrive_timeout", {7'd0, arrived}, 8'd1);
    endtask

    task automatic waitDoorClosed(input int limit);
        int n = 0;
        while (doorState !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        check("door_close_timeout", {7'd0, doorState}, 8'd0);
    endtask

    initial begin
        reset          = 1'b0;
        enable         = 1'b1;
        nextDirection  = 2'b00;
        floorButton    = '0;
        internalButton = '0;
`ifdef DOOR_REOPEN_EN
        doorObstruct   = 1'b0;
`endif
        tick(2);
        check("rst_floor", 8'(currentFloor), 8'd1);
        check("rst_dir", 8'(currentDirection), 8'd0);
        check("rst_move", 8'(move), 8'd0);
        check("rst_door", 8'(doorState), 8'd0);
        check("rst_arrived", 8'(arrived), 8'd0);
        reset = 1'b1;

        // Floor 1 to 4 on a cabin call, exact tick timing
        internalButton = 7'b0001000;
        nextDirection  = 2'b10;
        tick();
        check("t2_move_start", 8'(move), 8'd1);
        check("t2_dir_up", 8'(currentDirection), 8'd2);
        tick(7);
        check("t2_floor1_still", 8'(currentFloor), 8'd1);
        tick();
        check("t2_floor2", 8'(currentFloor), 8'd2);
        tick();
        check("t2_pass2_arrived", 8'(arrived), 8'd0);
        check("t2_pass2_move", 8'(move), 8'd1);
        tick(8);
        check("t2_floor3", 8'(currentFloor), 8'd3);
        tick();
        check("t2_pass3_arrived", 8'(arrived), 8'd0);
        tick(8);
        check("t2_floor4", 8'(currentFloor), 8'd4);
        tick();
        check("t2_arrived", 8'(arrived), 8'd1);
        check("t2_door_open", 8'(doorState), 8'd1);
        check("t2_move_hold", 8'(move), 8'd0);
        internalButton = '0;
        nextDirection  = 2'b00;
        tick();
        check("t2_arrived_drop", 8'(arrived), 8'd0);
        check("t2_door_tick1", 8'(doorState), 8'd1);
        tick(4);
        check("t2_door_tick5", 8'(doorState), 8'd1);
        tick();
        check("t2_door_closed", 8'(doorState), 8'd0);
        tick();
        check("t2_idle_move", 8'(move), 8'd0);
        check("t2_idle_dir", 8'(currentDirection), 8'd0);

        // Pass floor 3 despite a DOWN hall call there, stop at 5; enable gaps hold state
        reset = 1'b0;
        tick();
        reset          = 1'b1;
        floorButton    = 14'h0010;
        internalButton = 7'b0010000;
        nextDirection  = 2'b10;
        tick();
        enable = 1'b0;
        tick(3);
        check("t3_hold_floor", 8'(currentFloor), 8'd1);
        check("t3_hold_move", 8'(move), 8'd1);
        enable = 1'b1;
        waitArrived(100, took);
        check("t3_stop_floor5", 8'(currentFloor), 8'd5);
        check("t3_dir_up", 8'(currentDirection), 8'd2);
        enable = 1'b0;
        tick();
        check("t3_arrived_drop_noen", 8'(arrived), 8'd0);
        check("t3_door_open_noen", 8'(doorState), 8'd1);
        tick(8);
        check("t3_door_held", 8'(doorState), 8'd1);
        enable         = 1'b1;
        internalButton = '0;
        floorButton    = '0;
        nextDirection  = 2'b00;
        waitDoorClosed(20);

        // Up to the top floor, then door timing with and without obstruction
        internalButton = 7'b1000000;
        nextDirection  = 2'b10;
        waitArrived(100, took);
        check("t4_floor7", 8'(currentFloor), 8'd7);
        internalButton = '0;
        nextDirection  = 2'b00;
`ifdef DOOR_REOPEN_EN
        tick(4);
        doorObstruct = 1'b1;
        tick();
        doorObstruct = 1'b0;
        tick(5);
        check("t6_reopen_held", 8'(doorState), 8'd1);
        tick();
        check("t6_reopen_closed", 8'(doorState), 8'd0);
`else
        tick(5);
        check("t6_door_tick5", 8'(doorState), 8'd1);
        tick();
        check("t6_door_tick6", 8'(doorState), 8'd0);
`endif
        tick();
        nextDirection = 2'b10;
        tick(3);
        check("t4_top_move", 8'(move), 8'd0);
        check("t4_top_floor", 8'(currentFloor), 8'd7);
        check("t4_top_dir", 8'(currentDirection), 8'd2);
        nextDirection = 2'b11;
        tick();
        check("t4_updown_dir", 8'(currentDirection), 8'd0);
        check("t4_updown_move", 8'(move), 8'd0);

        // Down to 2, ignoring an UP hall call at 5
        floorButton    = 14'h0200;
        internalButton = 7'b0000010;
        nextDirection  = 2'b01;
        waitArrived(100, took);
        check("t4_down_floor2", 8'(currentFloor), 8'd2);
        check("t4_down_dir", 8'(currentDirection), 8'd1);
        internalButton = '0;
        floorButton    = '0;
        nextDirection  = 2'b00;
        waitDoorClosed(20);

        // Reset mid-travel between floors 2 and 3
        reset = 1'b0;
        tick();
        reset          = 1'b1;
        internalButton = 7'b0000100;
        nextDirection  = 2'b10;
        tick();
        tick(8);
        check("t5_floor2", 8'(currentFloor), 8'd2);
        tick();
        tick(3);
        check("t5_moving", 8'(move), 8'd1);
        reset = 1'b0;
        tick();
        check("t5_rst_floor", 8'(currentFloor), 8'd1);
        check("t5_rst_move", 8'(move), 8'd0);
        check("t5_rst_door", 8'(doorState), 8'd0);
        check("t5_rst_dir", 8'(currentDirection), 8'd0);
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
